// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the generic-bus to AHB master bridge.
// Holds the HTRANS/HSIZE/HBURST encodings, the bus widths, and the
// master FSM state type.
package ahb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } ahb_master_state_t;

endpackage

// File: rtl/generic_bus_ahb_master_if.sv
// Bundle of generic-bus request/response and AHB-Lite master signals.
// master: the bridge's view (accepts requests, drives AHB).
// slave : the environment's view (requester plus AHB slave).
interface generic_bus_ahb_master_if;

  logic [ahb_pkg::ADDR_W-1:0] addr;
  logic [ahb_pkg::DATA_W-1:0] wdata;
  logic                       ren;
  logic                       wen;
  logic [ahb_pkg::BE_W-1:0]   byte_en;
  logic [ahb_pkg::DATA_W-1:0] rdata;
  logic                       busy;
  logic                       bus_err;

  logic [ahb_pkg::ADDR_W-1:0] HADDR;
  logic                       HWRITE;
  logic [1:0]                 HTRANS;
  logic [2:0]                 HSIZE;
  logic [2:0]                 HBURST;
  logic [3:0]                 HPROT;
  logic                       HMASTLOCK;
  logic [ahb_pkg::DATA_W-1:0] HWDATA;
  logic [ahb_pkg::DATA_W-1:0] HRDATA;
  logic                       HREADY;
  logic                       HRESP;

  modport master (
    input  addr, wdata, ren, wen, byte_en, HRDATA, HREADY, HRESP,
    output rdata, busy, bus_err,
    output HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

  modport slave (
    output addr, wdata, ren, wen, byte_en, HRDATA, HREADY, HRESP,
    input  rdata, busy, bus_err,
    input  HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

endinterface

// File: rtl/ahb_size_decode.sv
// Maps generic-bus byte enables to AHB HSIZE and HADDR[1:0].
// Ports: i_byte_en (lane mask), o_hsize_c (transfer size),
//        o_haddr_lo_c (byte offset within the word).
// Irregular lane masks (including none) fall back to a full word.
module ahb_size_decode
  import ahb_pkg::*;
(
  input  logic [BE_W-1:0] i_byte_en,
  output logic [2:0]      o_hsize_c,
  output logic [1:0]      o_haddr_lo_c
);

  always_comb begin
    o_hsize_c    = HSIZE_WORD;
    o_haddr_lo_c = 2'd0;
    case (i_byte_en)
      4'b0011: o_hsize_c = HSIZE_HALF;
      4'b1100: begin o_hsize_c = HSIZE_HALF; o_haddr_lo_c = 2'd2; end
      4'b0001: o_hsize_c = HSIZE_BYTE;
      4'b0010: begin o_hsize_c = HSIZE_BYTE; o_haddr_lo_c = 2'd1; end
      4'b0100: begin o_hsize_c = HSIZE_BYTE; o_haddr_lo_c = 2'd2; end
      4'b1000: begin o_hsize_c = HSIZE_BYTE; o_haddr_lo_c = 2'd3; end
      default: ;
    endcase
  end

endmodule

// File: rtl/generic_bus_ahb_master.sv
// Generic-bus to AHB-Lite bridge issuing one NONSEQ/SINGLE transfer per
// request, single outstanding.
// Ports: CLK, nRST (async active-low), io_bus (master modport carrying the
// requester handshake and the AHB-Lite master signals).
// The address phase is driven straight from the request so a zero-wait
// transfer completes the cycle after it is seen; busy/rdata/bus_err follow
// HREADY combinationally in the data phase.
module generic_bus_ahb_master
  import ahb_pkg::*;
#(
  parameter logic [3:0]        HPROT_VAL = 4'b0011,
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'hBAD0_BAD0
) (
  input  logic                            CLK,
  input  logic                            nRST,
  generic_bus_ahb_master_if.master        io_bus
);

  ahb_master_state_t   r_state;
  logic                r_wr_q;
  logic                r_err_q;
  logic [DATA_W-1:0]   r_hwdata;

  logic                w_req;
  logic                w_accept;
  logic                w_done;
  logic                w_err;
  logic [2:0]          w_hsize;
  logic [1:0]          w_haddr_lo;
  logic                w_unused;

  ahb_size_decode u_size_decode (
    .i_byte_en    (io_bus.byte_en),
    .o_hsize_c    (w_hsize),
    .o_haddr_lo_c (w_haddr_lo)
  );

  // Address offset comes from the lane mask; the write flag is kept for
  // debug visibility only.
  assign w_unused = ^{io_bus.addr[1:0], r_wr_q};

  assign w_req    = nRST & (io_bus.ren | io_bus.wen);
  assign w_accept = (r_state == IDLE) & w_req & io_bus.HREADY;
  assign w_done   = (r_state == DATA) & io_bus.HREADY;
  assign w_err    = io_bus.HRESP | r_err_q;

  // State and data-phase bookkeeping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_wr_q   <= 1'b0;
      r_err_q  <= 1'b0;
      r_hwdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= DATA;
            r_wr_q   <= io_bus.wen;
            r_hwdata <= io_bus.wdata;
          end
        end
        DATA: begin
          if (io_bus.HREADY) begin
            r_state <= IDLE;
            r_err_q <= 1'b0;
          end else if (io_bus.HRESP) begin
            r_err_q <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Address phase and requester response.
  always_comb begin
    io_bus.HTRANS  = HTRANS_IDLE;
    io_bus.HADDR   = '0;
    io_bus.HWRITE  = 1'b0;
    io_bus.HSIZE   = HSIZE_WORD;
    io_bus.busy    = 1'b1;
    io_bus.bus_err = 1'b0;
    io_bus.rdata   = '0;
    if ((r_state == IDLE) && w_req) begin
      io_bus.HTRANS = HTRANS_NONSEQ;
      io_bus.HADDR  = {io_bus.addr[ADDR_W-1:2], w_haddr_lo};
      io_bus.HWRITE = io_bus.wen;
      io_bus.HSIZE  = w_hsize;
    end
    if (w_done) begin
      io_bus.busy    = 1'b0;
      io_bus.bus_err = w_err;
      io_bus.rdata   = w_err ? ERR_RDATA : io_bus.HRDATA;
    end
  end

  assign io_bus.HBURST    = HBURST_SINGLE;
  assign io_bus.HPROT     = HPROT_VAL;
  assign io_bus.HMASTLOCK = 1'b0;
  assign io_bus.HWDATA    = r_hwdata;

endmodule

// File: tb/tb_generic_bus_ahb_master.sv
// Directed self-checking bench for generic_bus_ahb_master.
module tb_generic_bus_ahb_master;

  logic CLK;
  logic nRST;
  int   vec;
  int   errs;

  generic_bus_ahb_master_if bus ();

  generic_bus_ahb_master dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .io_bus (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ren = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.byte_en = 4'hF; bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    bus.ren = 1'b1; bus.addr = 32'h0000_0010;
    #1;
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL reset_busy got %b exp 1", bus.busy); end
    vec++; if (bus.HTRANS !== 2'b00) begin errs++; $display("FAIL reset_htrans got %b exp 00", bus.HTRANS); end
    vec++; if (bus.HADDR !== 32'h0) begin errs++; $display("FAIL reset_haddr got %h exp 0", bus.HADDR); end
    vec++; if (bus.HWRITE !== 1'b0) begin errs++; $display("FAIL reset_hwrite got %b exp 0", bus.HWRITE); end
    vec++; if (bus.HSIZE !== 3'b010) begin errs++; $display("FAIL reset_hsize got %b exp 010", bus.HSIZE); end
    vec++; if (bus.HWDATA !== 32'h0) begin errs++; $display("FAIL reset_hwdata got %h exp 0", bus.HWDATA); end
    vec++; if (bus.rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata got %h exp 0", bus.rdata); end
    vec++; if (bus.bus_err !== 1'b0) begin errs++; $display("FAIL reset_bus_err got %b exp 0", bus.bus_err); end
    vec++; if ({bus.HBURST, bus.HPROT, bus.HMASTLOCK} !== {3'b000, 4'b0011, 1'b0})
      begin errs++; $display("FAIL reset_consts got %b/%b/%b exp 000/0011/0", bus.HBURST, bus.HPROT, bus.HMASTLOCK); end
    bus.ren = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_word_read();
    bus.ren = 1'b1; bus.addr = 32'h0000_1004; bus.byte_en = 4'hF;
    bus.HREADY = 1'b1; bus.HRDATA = 32'hDEAD_BEEF;
    #1;
    vec++; if (bus.HTRANS !== 2'b10) begin errs++; $display("FAIL rd_htrans got %b exp 10", bus.HTRANS); end
    vec++; if (bus.HADDR !== 32'h0000_1004) begin errs++; $display("FAIL rd_haddr got %h exp 00001004", bus.HADDR); end
    vec++; if (bus.HSIZE !== 3'b010) begin errs++; $display("FAIL rd_hsize got %b exp 010", bus.HSIZE); end
    vec++; if (bus.HWRITE !== 1'b0) begin errs++; $display("FAIL rd_hwrite got %b exp 0", bus.HWRITE); end
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL rd_busy0 got %b exp 1", bus.busy); end
    tick();
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rd_busy1 got %b exp 0", bus.busy); end
    vec++; if (bus.rdata !== 32'hDEAD_BEEF) begin errs++; $display("FAIL rd_rdata got %h exp deadbeef", bus.rdata); end
    vec++; if (bus.HTRANS !== 2'b00) begin errs++; $display("FAIL rd_htrans_data got %b exp 00", bus.HTRANS); end
    vec++; if (bus.bus_err !== 1'b0) begin errs++; $display("FAIL rd_bus_err got %b exp 0", bus.bus_err); end
    bus.ren = 1'b0;
    tick();
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL rd_busy2 got %b exp 1", bus.busy); end
    vec++; if (bus.rdata !== 32'h0) begin errs++; $display("FAIL rd_rdata_idle got %h exp 0", bus.rdata); end
  endtask

  task automatic test_byte_write();
    bus.wen = 1'b1; bus.addr = 32'h0000_2000; bus.byte_en = 4'b0100;
    bus.wdata = 32'h00AB_0000; bus.HREADY = 1'b1;
    #1;
    vec++; if (bus.HADDR !== 32'h0000_2002) begin errs++; $display("FAIL wr_haddr got %h exp 00002002", bus.HADDR); end
    vec++; if (bus.HSIZE !== 3'b000) begin errs++; $display("FAIL wr_hsize got %b exp 000", bus.HSIZE); end
    vec++; if (bus.HWRITE !== 1'b1) begin errs++; $display("FAIL wr_hwrite got %b exp 1", bus.HWRITE); end
    vec++; if (bus.HTRANS !== 2'b10) begin errs++; $display("FAIL wr_htrans got %b exp 10", bus.HTRANS); end
    tick();
    vec++; if (bus.HWDATA !== 32'h00AB_0000) begin errs++; $display("FAIL wr_hwdata got %h exp 00ab0000", bus.HWDATA); end
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL wr_busy got %b exp 0", bus.busy); end
    bus.wen = 1'b0;
    tick();
    vec++; if (bus.HWDATA !== 32'h00AB_0000) begin errs++; $display("FAIL wr_hwdata_hold got %h exp 00ab0000", bus.HWDATA); end
  endtask

  task automatic test_size_decode();
    logic [3:0] be_tab [10] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h5, 4'hE};
    logic [2:0] sz_tab [10] = '{3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2};
    logic [1:0] lo_tab [10] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    // HREADY low keeps the request in the address phase, so nothing is issued.
    bus.HREADY = 1'b0; bus.ren = 1'b1; bus.addr = 32'h0000_4007;
    for (int i = 0; i < 10; i++) begin
      bus.byte_en = be_tab[i];
      #1;
      vec++; if ({bus.HSIZE, bus.HADDR} !== {sz_tab[i], 30'h0000_1001, lo_tab[i]})
        begin errs++; $display("FAIL dec_be%h got size %b addr %h exp size %b lo %0d", be_tab[i], bus.HSIZE, bus.HADDR, sz_tab[i], lo_tab[i]); end
    end
    bus.ren = 1'b0; bus.byte_en = 4'hF;
    tick();
    bus.HREADY = 1'b1;
    tick();
  endtask

  task automatic test_wait_states();
    bus.ren = 1'b1; bus.addr = 32'h0000_3000; bus.byte_en = 4'hF;
    bus.HREADY = 1'b1; bus.HRDATA = 32'h1234_5678;
    tick();
    bus.ren = 1'b0; bus.HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++; if ({bus.busy, bus.HTRANS} !== {1'b1, 2'b00})
        begin errs++; $display("FAIL ws_wait%0d got busy %b htrans %b exp 1/00", i, bus.busy, bus.HTRANS); end
      if (i < 2) tick();
    end
    bus.HREADY = 1'b1; bus.HRDATA = 32'hCAFE_F00D;
    #1;
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL ws_busy got %b exp 0", bus.busy); end
    vec++; if (bus.rdata !== 32'hCAFE_F00D) begin errs++; $display("FAIL ws_rdata got %h exp cafef00d", bus.rdata); end
    tick();
  endtask

  task automatic test_error();
    bus.ren = 1'b1; bus.addr = 32'h0000_5000; bus.HREADY = 1'b1; bus.HRDATA = 32'h1111_2222;
    tick();
    bus.HREADY = 1'b0; bus.HRESP = 1'b1;
    #1;
    vec++; if ({bus.busy, bus.bus_err} !== 2'b10) begin errs++; $display("FAIL err_first got busy/err %b%b exp 10", bus.busy, bus.bus_err); end
    tick();
    bus.HREADY = 1'b1; bus.HRESP = 1'b1;
    #1;
    vec++; if ({bus.busy, bus.bus_err} !== 2'b01) begin errs++; $display("FAIL err_done got busy/err %b%b exp 01", bus.busy, bus.bus_err); end
    vec++; if (bus.rdata !== 32'hBAD0_BAD0) begin errs++; $display("FAIL err_rdata got %h exp bad0bad0", bus.rdata); end
    bus.ren = 1'b0;
    tick();
    bus.HRESP = 1'b0;
    #1;
    vec++; if ({bus.busy, bus.bus_err, bus.HTRANS} !== 4'b1000) begin errs++; $display("FAIL err_after got %b%b%b exp 1000", bus.busy, bus.bus_err, bus.HTRANS); end
    // Latched error alone still flags completion even if the final HRESP is OKAY.
    bus.ren = 1'b1;
    tick();
    bus.HREADY = 1'b0; bus.HRESP = 1'b1;
    tick();
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    #1;
    vec++; if ({bus.busy, bus.bus_err, bus.rdata} !== {2'b01, 32'hBAD0_BAD0})
      begin errs++; $display("FAIL err_latched got %b%b %h exp 01 bad0bad0", bus.busy, bus.bus_err, bus.rdata); end
    bus.ren = 1'b0;
    tick();
    // The error latch must not leak into a following clean read.
    bus.ren = 1'b1; bus.HRDATA = 32'h0BAD_0000;
    tick();
    vec++; if ({bus.busy, bus.bus_err, bus.rdata} !== {2'b00, 32'h0BAD_0000})
      begin errs++; $display("FAIL err_cleared got %b%b %h exp 00 0bad0000", bus.busy, bus.bus_err, bus.rdata); end
    bus.ren = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    bus.ren = 1'b1; bus.addr = 32'h0000_6000; bus.HREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vec++; if ({bus.HTRANS, bus.busy} !== 3'b101) begin errs++; $display("FAIL wd_pending%0d got %b%b exp 101", i, bus.HTRANS, bus.busy); end
      if (i == 0) tick();
    end
    tick();
    bus.ren = 1'b0;
    #1;
    vec++; if (bus.HTRANS !== 2'b00) begin errs++; $display("FAIL wd_dropped got %b exp 00", bus.HTRANS); end
    bus.HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if ({bus.busy, bus.HTRANS} !== 3'b100) begin errs++; $display("FAIL wd_idle%0d got %b%b exp 100", i, bus.busy, bus.HTRANS); end
    end
  endtask

  task automatic test_back_to_back();
    bus.ren = 1'b1; bus.addr = 32'h0000_7000; bus.HREADY = 1'b1; bus.HRDATA = 32'hAAAA_0001;
    tick();
    vec++; if ({bus.busy, bus.rdata} !== {1'b0, 32'hAAAA_0001}) begin errs++; $display("FAIL b2b_first got %b %h exp 0 aaaa0001", bus.busy, bus.rdata); end
    bus.addr = 32'h0000_7008; bus.HRDATA = 32'hAAAA_0002;
    tick();
    vec++; if ({bus.busy, bus.HTRANS, bus.HADDR} !== {1'b1, 2'b10, 32'h0000_7008})
      begin errs++; $display("FAIL b2b_addr got %b %b %h exp 1 10 00007008", bus.busy, bus.HTRANS, bus.HADDR); end
    tick();
    vec++; if ({bus.busy, bus.rdata} !== {1'b0, 32'hAAAA_0002}) begin errs++; $display("FAIL b2b_second got %b %h exp 0 aaaa0002", bus.busy, bus.rdata); end
    bus.ren = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.wen = 1'b1; bus.addr = 32'h0000_8000; bus.wdata = 32'h55AA_55AA; bus.HREADY = 1'b1;
    tick();
    bus.HREADY = 1'b0;
    #1;
    vec++; if ({bus.busy, bus.HWDATA} !== {1'b1, 32'h55AA_55AA}) begin errs++; $display("FAIL rm_wait got %b %h exp 1 55aa55aa", bus.busy, bus.HWDATA); end
    #1 nRST = 1'b0;
    #1;
    vec++; if ({bus.busy, bus.HTRANS, bus.HWDATA, bus.bus_err, bus.rdata} !== {1'b1, 2'b00, 32'h0, 1'b0, 32'h0})
      begin errs++; $display("FAIL rm_reset got busy %b htrans %b hwdata %h err %b rdata %h exp 1 00 0 0 0", bus.busy, bus.HTRANS, bus.HWDATA, bus.bus_err, bus.rdata); end
    bus.wen = 1'b0;
    tick();
    nRST = 1'b1; bus.HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if ({bus.busy, bus.bus_err, bus.HTRANS} !== 4'b1000) begin errs++; $display("FAIL rm_after%0d got %b%b%b exp 1000", i, bus.busy, bus.bus_err, bus.HTRANS); end
    end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    test_reset();
    test_word_read();
    test_byte_write();
    test_size_decode();
    test_wait_states();
    test_error();
    test_withdraw();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
